// File: rtl/board_7seg_bcd_display.sv
// Binary switch value to four 7-segment digits via a continuous 16-cycle double-dabble engine.
// Optional leading-zero blanking under BOARD_7SEG_LZB_EN; outputs update once per conversion.
module board_7seg_bcd_display (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] sw,
    output logic [6:0]  segment_1000,
    output logic [6:0]  segment_100,
    output logic [6:0]  segment_10,
    output logic [6:0]  segment_1
);
    localparam logic [1:0] LOAD  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    logic [1:0]  state;
    logic [1:0]  prime;
    logic [3:0]  iter;
    logic [13:0] sw_meta;
    logic [13:0] sw_sync;
    logic [13:0] bin;
    logic [15:0] bcd;
    logic [15:0] bcd_adj;
    logic        ovf;
    logic        blank_1000;
    logic        blank_100;
    logic        blank_10;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'h40;
            4'd1:    enc = 7'h79;
            4'd2:    enc = 7'h24;
            4'd3:    enc = 7'h30;
            4'd4:    enc = 7'h19;
            4'd5:    enc = 7'h12;
            4'd6:    enc = 7'h02;
            4'd7:    enc = 7'h78;
            4'd8:    enc = 7'h00;
            4'd9:    enc = 7'h10;
            default: enc = SEG_BLANK;
        endcase
    endfunction

    function automatic logic [3:0] adj3(input logic [3:0] d);
        adj3 = (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    always_comb begin
        bcd_adj = {adj3(bcd[15:12]), adj3(bcd[11:8]), adj3(bcd[7:4]), adj3(bcd[3:0])};
    end

    always_comb begin
        blank_1000 = 1'b0;
        blank_100  = 1'b0;
        blank_10   = 1'b0;
`ifdef BOARD_7SEG_LZB_EN
        blank_1000 = (bcd[15:12] == 4'd0);
        blank_100  = blank_1000 && (bcd[11:8] == 4'd0);
        blank_10   = blank_100 && (bcd[7:4] == 4'd0);
`endif
    end

    // LOAD idles for two cycles after reset so the first capture sees a primed synchronizer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= LOAD;
            prime        <= 2'd0;
            iter         <= 4'd0;
            sw_meta      <= 14'd0;
            sw_sync      <= 14'd0;
            bin          <= 14'd0;
            bcd          <= 16'd0;
            ovf          <= 1'b0;
            segment_1000 <= SEG_BLANK;
            segment_100  <= SEG_BLANK;
            segment_10   <= SEG_BLANK;
            segment_1    <= SEG_BLANK;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
            case (state)
                LOAD: begin
                    if (prime != 2'd2) begin
                        prime <= prime + 2'd1;
                    end else begin
                        bin   <= sw_sync;
                        ovf   <= (sw_sync > 14'd9999);
                        bcd   <= 16'd0;
                        iter  <= 4'd0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd  <= {bcd_adj[14:0], bin[13]};
                    bin  <= {bin[12:0], 1'b0};
                    iter <= iter + 4'd1;
                    if (iter == 4'd13) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (ovf) begin
                        segment_1000 <= SEG_DASH;
                        segment_100  <= SEG_DASH;
                        segment_10   <= SEG_DASH;
                        segment_1    <= SEG_DASH;
                    end else begin
                        segment_1000 <= blank_1000 ? SEG_BLANK : enc(bcd[15:12]);
                        segment_100  <= blank_100  ? SEG_BLANK : enc(bcd[11:8]);
                        segment_10   <= blank_10   ? SEG_BLANK : enc(bcd[7:4]);
                        segment_1    <= enc(bcd[3:0]);
                    end
                    state <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_board_7seg_bcd_display.sv
// Bench for board_7seg_bcd_display: decimal reference model with per-cycle scoreboard,
// literal vector table, mid-conversion input change and asynchronous reset sequences.
module tb_board_7seg_bcd_display;
    logic        clk;
    logic        reset;
    logic [13:0] sw;
    logic [6:0]  segment_1000;
    logic [6:0]  segment_100;
    logic [6:0]  segment_10;
    logic [6:0]  segment_1;
    logic [27:0] outs;

    int checks;
    int errors;
    int cyc;
    int hist [4096];
    logic [27:0] exp_cur;

    localparam logic [27:0] ALL_BLANK = {4{7'h7F}};
    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    typedef struct {
        int         val;
        logic [6:0] e1000;
        logic [6:0] e100;
        logic [6:0] e10;
        logic [6:0] e1;
    } vec_t;

    vec_t vecs [10];

    board_7seg_bcd_display dut (
        .clk          (clk),
        .reset        (reset),
        .sw           (sw),
        .segment_1000 (segment_1000),
        .segment_100  (segment_100),
        .segment_10   (segment_10),
        .segment_1    (segment_1)
    );

    assign outs = {segment_1000, segment_100, segment_10, segment_1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [27:0] model(input int v);
        int d [4];
        logic [6:0] s [4];
        if (v > 9999) return {4{7'h3F}};
        d[3] = v / 1000;
        d[2] = (v / 100) % 10;
        d[1] = (v / 10) % 10;
        d[0] = v % 10;
        for (int i = 0; i < 4; i++) s[i] = seg_tab[d[i]];
`ifdef BOARD_7SEG_LZB_EN
        if (v < 1000) s[3] = 7'h7F;
        if (v < 100)  s[2] = 7'h7F;
        if (v < 10)   s[1] = 7'h7F;
`endif
        return {s[3], s[2], s[1], s[0]};
    endfunction

    task automatic chk(input string name, input logic [27:0] got, input logic [27:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %h exp %h", name, cyc, got, exp);
        end
    endtask

    function automatic bit is_update(input int c);
        return (c >= 18) && (((c - 18) % 16) == 0);
    endfunction

    // One clock: record the input seen at the edge, then check outputs against the model.
    task automatic step();
        @(posedge clk);
        cyc++;
        hist[cyc] = int'(sw);
        #1;
        if (is_update(cyc)) exp_cur = model(hist[cyc - 17]);
        chk("scoreboard", outs, exp_cur);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic align_update();
        for (int i = 0; i < 16; i++) begin
            if (is_update(cyc)) return;
            step();
        end
        chk("align_timeout", 28'd0, 28'd1);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset   = 1'b0;
        cyc     = 0;
        exp_cur = ALL_BLANK;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        exp_cur = ALL_BLANK;
        reset   = 1'b1;
        sw      = 14'd0;

        vecs[0] = '{0,     7'h40, 7'h40, 7'h40, 7'h40};
        vecs[1] = '{807,   7'h40, 7'h00, 7'h40, 7'h78};
        vecs[2] = '{777,   7'h40, 7'h78, 7'h78, 7'h78};
`ifdef BOARD_7SEG_LZB_EN
        vecs[0] = '{0,     7'h7F, 7'h7F, 7'h7F, 7'h40};
        vecs[1] = '{807,   7'h7F, 7'h00, 7'h40, 7'h78};
        vecs[2] = '{777,   7'h7F, 7'h78, 7'h78, 7'h78};
`endif
        vecs[3] = '{1023,  7'h79, 7'h40, 7'h24, 7'h30};
        vecs[4] = '{6025,  7'h02, 7'h40, 7'h24, 7'h12};
        vecs[5] = '{7777,  7'h78, 7'h78, 7'h78, 7'h78};
        vecs[6] = '{9999,  7'h10, 7'h10, 7'h10, 7'h10};
        vecs[7] = '{10000, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        vecs[8] = '{16383, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        vecs[9] = vecs[0];

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("reset_hold", outs, ALL_BLANK);
        end
        release_reset();
        steps(17);
        chk("first_update_pending", outs, ALL_BLANK);
        step();
        chk("first_update_zero", outs, {vecs[0].e1000, vecs[0].e100, vecs[0].e10, vecs[0].e1});

        for (int i = 0; i < 10; i++) begin
            sw = 14'(vecs[i].val);
            steps(34);
            chk($sformatf("vec_%0d", vecs[i].val), outs,
                {vecs[i].e1000, vecs[i].e100, vecs[i].e10, vecs[i].e1});
            steps(6);
        end

        sw = 14'd1234;
        steps(34);
        align_update();
        steps(8);
        sw = 14'd4321;
        steps(8);
        chk("midshift_old", outs, {7'h79, 7'h24, 7'h30, 7'h19});
        steps(8);
        chk("midshift_old_update", outs, {7'h79, 7'h24, 7'h30, 7'h19});
        steps(16);
        chk("midshift_new", outs, {7'h19, 7'h30, 7'h24, 7'h79});

        sw = 14'd9999;
        steps(34);
        align_update();
        steps(8);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_blank", outs, ALL_BLANK);
        @(posedge clk);
        #1;
        chk("reset_held_blank", outs, ALL_BLANK);
        release_reset();
        steps(17);
        chk("post_reset_pending", outs, ALL_BLANK);
        step();
        chk("post_reset_9999", outs, {4{7'h10}});

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) sw = 14'($urandom_range(9990, 10010));
            else                           sw = 14'($urandom_range(0, 16383));
            steps(int'($urandom_range(1, 40)));
        end
        steps(34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
